spi_master_multi: RTL
=====================

Name: spi_master_multi

Overview:
Parametrised successor to the single-mode 8-bit SPI master. It adds configurable word width and clock divider, and supports run-time selection of SPI mode (CPOL/CPHA) and bit order per transfer. It drives multiple chip selects, with optional CS hold across back-to-back words for bursts. It sits on the SoC peripheral bus side of the SPI controller, clocked by rclk.

Parameters:
DATA_WIDTH, 8, bits per transfer word (>=2).
CLK_DIV, 2, rclk cycles per SPI half-period (>=1); default gives 4 rclk per SPI clock.
NUM_CS, 4, number of active-low chip-select lines (>=1).
CS_W, max(1,clog2(NUM_CS)), width of cs_sel (derived localparam, not overridden).

Ports:
rclk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a transfer; sampled only when busy=0.
tx_data  input  DATA_WIDTH  word to send, latched when start is accepted.
cs_sel  input  CS_W  chip-select index, latched with start.
cfg_cpol  input  1  clock idle level, latched with start.
cfg_cpha  input  1  0: sample on leading edge; 1: sample on trailing edge. Latched with start.
cfg_lsb_first  input  1  1: LSB shifted first. Latched with start.
keep_cs  input  1  1: leave CS asserted after the word completes. Latched with start.
cs_release  input  1  single-cycle pulse; deasserts any held CS while idle.
rx_data  output  DATA_WIDTH  last received word.
busy  output  1  transfer in progress.
ready  output  1  one-cycle completion pulse.
spi_clk  output  1  SPI serial clock.
spi_mosi  output  1  SPI data out.
spi_miso  input  1  SPI data in.
spi_cs_n  output  NUM_CS  active-low chip selects.

Behaviour:
- Reset (async, rst_n=0): busy=0, ready=0, rx_data=0, spi_clk=0, spi_mosi=0, spi_cs_n=all 1s, FSM to IDLE. Reset mid-transfer aborts immediately; no ready pulse is generated.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - spi_clk follows cfg_cpol, except that while a CS is held it keeps the latched CPOL.
  - start=1 is accepted at the rclk edge. All config and tx_data are latched, busy=1 from the next cycle, and the selected spi_cs_n bit goes to 0 on the next cycle.
  - If a different CS is currently held, it is released in that same cycle.
  - cs_sel >= NUM_CS: the transfer runs with no CS asserted.
- SETUP: lasts CLK_DIV cycles. spi_clk = CPOL. For CPHA=0 the first data bit is on spi_mosi from the first SETUP cycle.
- SHIFT:
  - 2*DATA_WIDTH half-periods of CLK_DIV cycles each; spi_clk toggles at each half-period boundary.
  - CPHA=0: sample MISO on odd (leading) edges, drive the next MOSI bit on even edges.
  - CPHA=1: drive MOSI on leading edges, sample on trailing edges.
  - Bit order follows lsb_first. The last edge returns spi_clk to CPOL.
- HOLD: CLK_DIV cycles, spi_mosi held. On exit:
  - rx_data is updated and ready=1 for exactly one cycle, while busy=0 in that same cycle.
  - If keep_cs=0, CS is deasserted in that same cycle; if keep_cs=1, CS stays low.
- Latency: the ready pulse occurs exactly (2*DATA_WIDTH+2)*CLK_DIV+1 rclk cycles after the start-accept edge. DATA_WIDTH=8, CLK_DIV=2 gives 37 cycles.
- start while busy=1: ignored, no queuing.
- start in the same cycle as ready: accepted; the back-to-back transfer re-enters SETUP.
- cs_release while busy: ignored. cs_release together with start in IDLE: start wins for the new CS, and any other held CS is released.
- rx_data is stable between ready pulses and is never partially updated.

Test Plan:
- Mode 0, CLK_DIV=2, tx=0xA5, MISO looped to MOSI -> rx_data=0xA5, ready at cycle 37, spi_cs_n[0] low throughout and high on the ready cycle.
- Mode 3, cs_sel=2, tx=0x3C, MISO tied 1 -> rx_data=0xFF, spi_clk idles high, only spi_cs_n[2] toggles, and MOSI transitions only on falling edges.
- DATA_WIDTH=16, lsb_first=1, tx=0x8001 -> first MOSI bit=1, second=0, last=1; slave model drives 0x1234 LSB-first -> rx_data=0x1234.
- Burst: keep_cs=1 for words 0x11 and 0x22, then keep_cs=0 for 0x33, started on each ready pulse -> spi_cs_n[1] stays low across all three and rises only on the third ready.
- Ignored start: pulse start mid-transfer with tx=0xEE -> exactly one ready pulse and original data on MOSI. Then hold CS with keep_cs=1 and pulse cs_release -> CS high the next cycle.
- Reset mid-SHIFT (bit 4) -> outputs return to reset values asynchronously with no ready pulse; a subsequent transfer of 0x5A completes normally.

Source files
------------

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - Multi-mode SPI master with configurable width, divider and chip selects
// Mode, bit order and CS are latched per word; CS may be held across words for bursts.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 4,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic                  keep_cs,
  input  logic                  cs_release,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  ready,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [NUM_CS-1:0]     spi_cs_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t                r_state, w_next;
  logic [DIV_W-1:0]      r_div;
  logic [EDGE_W-1:0]     r_edge;
  logic                  r_sclk, r_mosi, r_ready;
  logic [NUM_CS-1:0]     r_cs_n, w_cs_sel_n;
  logic                  r_cs_held;
  logic                  r_cpol, r_cpha, r_lsb, r_keep;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic                  w_div_end, w_last_edge, w_leading, w_tick, w_drive, w_sample;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d, input logic lsb);
    return lsb ? {1'b0, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], 1'b0};
  endfunction

  assign w_div_end   = (r_div == DIV_LAST);
  assign w_last_edge = (r_edge == EDGE_LAST);
  assign w_leading   = ~r_edge[0];
  assign w_tick      = (r_state == S_SHIFT) && w_div_end;
  // CPHA=0 preloads bit 0 at accept, so the final trailing edge has nothing left to drive
  assign w_drive     = w_tick && (r_cpha ? w_leading : (!w_leading && !w_last_edge));
  assign w_sample    = w_tick && (r_cpha ? !w_leading : w_leading);

  always_comb begin
    w_cs_sel_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) w_cs_sel_n[i] = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: if (w_div_end) w_next = S_SHIFT;
      S_SHIFT: if (w_div_end && w_last_edge) w_next = S_HOLD;
      S_HOLD:  if (w_div_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_edge    <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ready   <= 1'b0;
      r_cs_n    <= '1;
      r_cs_held <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_keep    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
    end else begin
      r_ready <= 1'b0;
      if (r_state == S_IDLE) r_div <= '0;
      else                   r_div <= w_div_end ? '0 : r_div + 1'b1;
      if (r_state != S_SHIFT) r_edge <= '0;
      else if (w_div_end)     r_edge <= r_edge + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_sclk <= r_cs_held ? r_cpol : cfg_cpol;
          if (start) begin
            r_cpol    <= cfg_cpol;
            r_cpha    <= cfg_cpha;
            r_lsb     <= cfg_lsb_first;
            r_keep    <= keep_cs;
            r_sclk    <= cfg_cpol;
            r_cs_n    <= w_cs_sel_n;
            r_cs_held <= 1'b0;
            r_tx      <= cfg_cpha ? tx_data : shift_out(tx_data, cfg_lsb_first);
            if (!cfg_cpha) r_mosi <= first_bit(tx_data, cfg_lsb_first);
          end else if (cs_release) begin
            r_cs_n    <= '1;
            r_cs_held <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_tick) r_sclk <= ~r_sclk;
          if (w_drive) begin
            r_mosi <= first_bit(r_tx, r_lsb);
            r_tx   <= shift_out(r_tx, r_lsb);
          end
          if (w_sample) begin
            r_rx <= r_lsb ? {spi_miso, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], spi_miso};
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_rx_data <= r_rx;
            r_ready   <= 1'b1;
            r_cs_held <= r_keep;
            if (!r_keep) r_cs_n <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data  = r_rx_data;
  assign busy     = (r_state != S_IDLE);
  assign ready    = r_ready;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;

endmodule
